// File: rtl/fwd_sel_pipe.sv
// EX operand forwarding-select generator with load-use stall; tracks dest tags through ID/EX, EX/MEM, MEM/WB.
// Selects are registered (1 cycle after ID); stall is combinational and holds PC/IF-ID while a bubble enters ID/EX.
module fwd_sel_pipe #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_alt_a,
    input  logic              id_alt_b,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              ex_valid,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_reg_write
);

    localparam logic [REG_AW-1:0] LP_ZERO = REG_AW'(ZERO_REG);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } tag_t;

    tag_t       r_idex;
    tag_t       r_exmem;
    tag_t       r_memwb;
    logic [1:0] r_fwd_sel_a;
    logic [1:0] r_fwd_sel_b;

    logic       w_stall;
    logic       w_bubble;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    tag_t       w_id_tag;

    function automatic logic f_hit(input tag_t t, input logic [REG_AW-1:0] r);
        return t.vld & t.reg_write & (t.dest == r) & (r != LP_ZERO);
    endfunction

    function automatic logic [1:0] f_sel(input logic alt, input logic uses,
                                         input logic [REG_AW-1:0] r,
                                         input tag_t idex, input tag_t exmem);
        if (alt)                          return 2'd3;
        else if (uses && f_hit(idex, r))  return 2'd1;
        else if (uses && f_hit(exmem, r)) return 2'd2;
        else                              return 2'd0;
    endfunction

    // Reset gates the stall so a held consumer is released in the reset cycle itself.
    always_comb begin
        w_stall = !rst & id_valid & !flush & r_idex.vld & r_idex.mem_read &
                  (r_idex.dest != LP_ZERO) &
                  ((id_uses_rs & (id_rs == r_idex.dest)) |
                   (id_uses_rt & (id_rt == r_idex.dest)));
        w_bubble = w_stall | flush | !id_valid;
        w_sel_a  = f_sel(id_alt_a, id_uses_rs, id_rs, r_idex, r_exmem);
        w_sel_b  = f_sel(id_alt_b, id_uses_rt, id_rt, r_idex, r_exmem);
        w_id_tag = '{vld: 1'b1, dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex      <= '0;
            r_exmem     <= '0;
            r_memwb     <= '0;
            r_fwd_sel_a <= 2'd0;
            r_fwd_sel_b <= 2'd0;
        end else begin
            r_memwb <= r_exmem;
            r_exmem <= r_idex;
            if (w_bubble) begin
                r_idex      <= '0;
                r_fwd_sel_a <= 2'd0;
                r_fwd_sel_b <= 2'd0;
            end else begin
                r_idex      <= w_id_tag;
                r_fwd_sel_a <= w_sel_a;
                r_fwd_sel_b <= w_sel_b;
            end
        end
    end

    assign stall        = w_stall;
    assign fwd_sel_a    = r_fwd_sel_a;
    assign fwd_sel_b    = r_fwd_sel_b;
    assign ex_valid     = r_idex.vld;
    assign wb_dest      = r_memwb.dest;
    assign wb_reg_write = r_memwb.vld & r_memwb.reg_write;

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Directed bench for fwd_sel_pipe: inputs driven 1ns after the rising edge, outputs sampled there too.
module tb_fwd_sel_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic       id_alt_a, id_alt_b, flush;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       stall, ex_valid, wb_reg_write;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [4:0] wb_dest;

    int checks = 0;
    int errors = 0;

    fwd_sel_pipe #(.REG_AW(5), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_alt_a(id_alt_a), .id_alt_b(id_alt_b), .flush(flush),
        .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .ex_valid(ex_valid), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] dest, input logic rw,
                         input logic mr, input logic aa, input logic ab);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr; id_alt_a = aa; id_alt_b = ab;
        flush = 1'b0;
        #1;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_alt_a = 1'b0;
        id_alt_b = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    task automatic test_reset();
        nop();
        rst = 1'b1;
        repeat (2) step();
        checks++; if ({stall, fwd_sel_a, fwd_sel_b, ex_valid, wb_reg_write, wb_dest} !== 12'h000) begin
            errors++; $display("FAIL reset_outputs got=%h want=000", {stall, fwd_sel_a, fwd_sel_b, ex_valid, wb_reg_write, wb_dest});
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        drain();
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);   // add r3 <- r1, r2
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_add got=%b want=0", stall); end
        step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b1_00_00) begin
            errors++; $display("FAIL b2b_add_ex got=%b want=10000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
        drive(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0);   // sub r4 <- r3, r5
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_sub got=%b want=0", stall); end
        step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b1_01_00) begin
            errors++; $display("FAIL b2b_sub_ex got=%b want=10100", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
    endtask

    task automatic test_distance();
        drain();
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step();
        drive(5'd8, 5'd9, 1, 1, 5'd10, 1, 0, 0, 0); step();
        drive(5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0); step();    // or r6 <- r5, r3
        checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b00_10) begin
            errors++; $display("FAIL dist2_sel got=%b want=0010", {fwd_sel_a, fwd_sel_b});
        end
        drain();
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step();
        drive(5'd8, 5'd9, 1, 1, 5'd10, 1, 0, 0, 0); step();
        drive(5'd8, 5'd9, 1, 1, 5'd11, 1, 0, 0, 0); step();
        checks++; if ({wb_reg_write, wb_dest} !== 6'b1_00011) begin
            errors++; $display("FAIL dist3_wb got=%b want=100011", {wb_reg_write, wb_dest});
        end
        drive(5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0); step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b1_00_00) begin
            errors++; $display("FAIL dist3_sel got=%b want=10000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
    endtask

    task automatic test_double_hit();
        drain();
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step();
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step();
        drive(5'd3, 5'd3, 1, 1, 5'd7, 1, 0, 0, 0); step();    // and r7 <- r3, r3
        checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b01_01) begin
            errors++; $display("FAIL double_hit got=%b want=0101", {fwd_sel_a, fwd_sel_b});
        end
    endtask

    task automatic test_load_use();
        drain();
        drive(5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0); step();    // lw r4
        drive(5'd4, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0);            // add r5 <- r4, r1
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on got=%b want=1", stall); end
        step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b0_00_00) begin
            errors++; $display("FAIL lu_bubble got=%b want=00000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off got=%b want=0", stall); end
        step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b1_10_00) begin
            errors++; $display("FAIL lu_add_ex got=%b want=11000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
        checks++; if ({wb_reg_write, wb_dest} !== 6'b1_00100) begin
            errors++; $display("FAIL lu_wb got=%b want=100100", {wb_reg_write, wb_dest});
        end
    endtask

    task automatic test_zero_alt();
        drain();
        drive(5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0, 0); step();    // writes r0
        drive(5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0, 0); step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b1_00_00) begin
            errors++; $display("FAIL zero_reg got=%b want=10000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step();
        drive(5'd1, 5'd3, 1, 1, 5'd8, 1, 0, 0, 1); step();    // addi, rt hit overridden by immediate
        checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b00_11) begin
            errors++; $display("FAIL alt_b got=%b want=0011", {fwd_sel_a, fwd_sel_b});
        end
        drive(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0); step();    // lw r0
        drive(5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_r0_stall got=%b want=0", stall); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lw_r0_ex got=%b want=1", ex_valid); end
    endtask

    task automatic test_flush();
        drain();
        drive(5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0); step();
        drive(5'd4, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall); end
        step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b0_00_00) begin
            errors++; $display("FAIL flush_bubble got=%b want=00000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        drain();
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step();
        drive(5'd3, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0); step();
        drive(5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0); step();
        drive(5'd4, 5'd3, 1, 1, 5'd5, 1, 0, 0, 0);
        checks++; if ({stall, wb_reg_write, wb_dest} !== 7'b1_1_00011) begin
            errors++; $display("FAIL pre_reset got=%b want=1100011", {stall, wb_reg_write, wb_dest});
        end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b want=0", stall); end
        step();
        checks++; if ({stall, fwd_sel_a, fwd_sel_b, ex_valid, wb_reg_write, wb_dest} !== 12'h000) begin
            errors++; $display("FAIL rst_mid_outputs got=%h want=000", {stall, fwd_sel_a, fwd_sel_b, ex_valid, wb_reg_write, wb_dest});
        end
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall got=%b want=0", stall); end
        step();
        checks++; if ({ex_valid, fwd_sel_a, fwd_sel_b} !== 5'b1_00_00) begin
            errors++; $display("FAIL post_rst_sel got=%b want=10000", {ex_valid, fwd_sel_a, fwd_sel_b});
        end
    endtask

    initial begin
        nop();
        step();
        test_reset();
        test_back_to_back();
        test_distance();
        test_double_hit();
        test_load_use();
        test_zero_alt();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
